// File: rtl/gfx_rom_pkg.sv
// Shared types and constants for the graphics ROM arbiter.
//   state_e      : arbiter FSM states
//   rom_word_t   : captured 32-bit word {hi, lo} from the K19/K13 ROM pair
//   ROM_AW/ROM_DW: ROM word-address and per-chip data widths
package gfx_rom_pkg;

    localparam int unsigned ROM_AW                = 18;
    localparam int unsigned ROM_DW                = 16;
    localparam int unsigned DEFAULT_ACCESS_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_e;

    typedef struct packed {
        logic [ROM_DW-1:0] hi;
        logic [ROM_DW-1:0] lo;
    } rom_word_t;

endpackage

// File: rtl/gfx_rom_arbiter_rr_arb2.sv
// Two-input round-robin grant logic (combinational).
//   req[1:0]  : in  request vector, bit 0 = tile, bit 1 = sprite
//   prio      : in  side that wins when both request (0 = tile)
//   advance   : in  a grant is being taken this cycle
//   gnt[1:0]  : out one-hot grant (zero when no request)
//   next_prio : out priority to load into the owner's prio register
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       next_prio
);

    // Single requester always wins; contention resolved by prio.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After a grant, priority moves to the side that was not served.
    always_comb begin
        next_prio = prio;
        if (advance && (gnt != 2'b00)) begin
            next_prio = gnt[0];
        end
    end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// Arbitrates the K13/K19 graphics ROM pair between the tile fetch path and
// the sprite fetch path, drives the shared ROM control lines, waits
// ACCESS_CYCLES clocks for the access time and returns the word with a
// one-cycle ack to the granted requester.
//   clk, reset            : clock, synchronous active-high reset
//   t_req/t_addr/t_ack    : tile requester handshake
//   s_req/s_addr/s_ack    : sprite requester handshake
//   rd_data               : captured {hi, lo} word, valid in the ack cycle
//   busy                  : high whenever the FSM is not idle
//   rom_addr/cen/oen      : registered ROM address and active-low controls
//   rom_lo_data/hi_data   : K13 / K19 data buses
module gfx_rom_arbiter
    import gfx_rom_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
    parameter int unsigned AW            = ROM_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                t_req,
    input  logic [AW-1:0]       t_addr,
    output logic                t_ack,
    input  logic                s_req,
    input  logic [AW-1:0]       s_addr,
    output logic                s_ack,
    output logic [2*ROM_DW-1:0] rd_data,
    output logic                busy,
    output logic [AW-1:0]       rom_addr,
    output logic                rom_cen,
    output logic                rom_oen,
    input  logic [ROM_DW-1:0]   rom_lo_data,
    input  logic [ROM_DW-1:0]   rom_hi_data
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             cen_q, cen_d;
    logic             oen_q, oen_d;
    logic             t_ack_q, t_ack_d;
    logic             s_ack_q, s_ack_d;
    rom_word_t        rd_data_q, rd_data_d;
    logic             busy_q, busy_d;
    logic             sel_q, sel_d;      // granted side: 0 tile, 1 sprite
    logic             prio_q, prio_d;

    logic [1:0]       req_c;
    logic [1:0]       gnt_c;
    logic             advance_c;
    logic             next_prio_c;

    assign req_c     = {s_req, t_req};
    assign advance_c = (state_q == IDLE) && (req_c != 2'b00);

    rr_arb2 u_arb (
        .req       (req_c),
        .prio      (prio_q),
        .advance   (advance_c),
        .gnt       (gnt_c),
        .next_prio (next_prio_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        cen_d     = cen_q;
        oen_d     = oen_q;
        t_ack_d   = 1'b0;
        s_ack_d   = 1'b0;
        rd_data_d = rd_data_q;
        sel_d     = sel_q;
        prio_d    = next_prio_c;

        unique case (state_q)
            IDLE: begin
                if (gnt_c != 2'b00) begin
                    sel_d   = gnt_c[1];
                    addr_d  = gnt_c[1] ? s_addr : t_addr;
                    cen_d   = 1'b0;
                    oen_d   = 1'b0;
                    cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rd_data_d.hi = rom_hi_data;
                    rd_data_d.lo = rom_lo_data;
                    t_ack_d      = ~sel_q;
                    s_ack_d      = sel_q;
                    cen_d        = 1'b1;
                    oen_d        = 1'b1;
                    state_d      = RECOVER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // Bus turnaround: ROM outputs release before the next grant.
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            cen_q     <= 1'b1;
            oen_q     <= 1'b1;
            t_ack_q   <= 1'b0;
            s_ack_q   <= 1'b0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            sel_q     <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            cen_q     <= cen_d;
            oen_q     <= oen_d;
            t_ack_q   <= t_ack_d;
            s_ack_q   <= s_ack_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            sel_q     <= sel_d;
            prio_q    <= prio_d;
        end
    end

    assign t_ack    = t_ack_q;
    assign s_ack    = s_ack_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign rom_addr = addr_q;
    assign rom_cen  = cen_q;
    assign rom_oen  = oen_q;

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Scoreboard bench for gfx_rom_arbiter: directed cases followed by two
// independent random requesters; a monitor predicts grant order from the
// round-robin rules and checks timing, address and returned data.
module tb_gfx_rom_arbiter;

    localparam int unsigned AC = 8;
    localparam int unsigned AW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          t_req, s_req;
    logic [AW-1:0] t_addr, s_addr;
    logic          t_ack, s_ack;
    logic [31:0]   rd_data;
    logic          busy;
    logic [AW-1:0] rom_addr;
    logic          rom_cen, rom_oen;
    logic [15:0]   rom_lo_data, rom_hi_data;

    gfx_rom_arbiter #(.ACCESS_CYCLES(AC), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .t_req       (t_req),
        .t_addr      (t_addr),
        .t_ack       (t_ack),
        .s_req       (s_req),
        .s_addr      (s_addr),
        .s_ack       (s_ack),
        .rd_data     (rd_data),
        .busy        (busy),
        .rom_addr    (rom_addr),
        .rom_cen     (rom_cen),
        .rom_oen     (rom_oen),
        .rom_lo_data (rom_lo_data),
        .rom_hi_data (rom_hi_data)
    );

    always #10 clk = ~clk;

    // ROM contents: fixed scrambles of the address.
    function automatic logic [15:0] lo_fn(input logic [AW-1:0] a);
        return a[15:0] ^ {a[17:16], a[17:16], 12'h5A3};
    endfunction
    function automatic logic [15:0] hi_fn(input logic [AW-1:0] a);
        return {a[3:0], a[17:6]} + 16'h1C3B;
    endfunction
    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return {hi_fn(a), lo_fn(a)};
    endfunction

    // ROM pair with 70 ns access time.
    assign #70 rom_lo_data = (!rom_cen && !rom_oen) ? lo_fn(rom_addr) : 16'hxxxx;
    assign #70 rom_hi_data = (!rom_cen && !rom_oen) ? hi_fn(rom_addr) : 16'hxxxx;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at t=%0t", nm, $time);
    endtask

    // Scoreboard state.
    logic [31:0]   t_exp_q[$];
    logic [31:0]   s_exp_q[$];
    int            win_q[$];
    int            cur_win    = -1;
    int            model_next = 0;   // side holding priority: 0 tile, 1 sprite
    bit            scribble   = 0;
    int            ack_cnt    = 0;

    // Monitor: samples inputs at the edge, outputs 1 ns later.
    int            cyc = 0;
    int            last_grant = 0;
    bit            have_last = 0;
    bit            exact_next = 0;
    bit            prev_cen = 1;
    int            low_cnt = 0;
    logic [AW-1:0] grant_addr = '0;
    logic          rst_s, tr_s, sr_s;
    logic [AW-1:0] ta_s, sa_s;

    always begin
        @(posedge clk);
        rst_s = reset; tr_s = t_req; sr_s = s_req; ta_s = t_addr; sa_s = s_addr;
        cyc++;
        #1;
        if (rst_s) begin
            chk("rst_cen", rom_cen, 1);
            chk("rst_oen", rom_oen, 1);
            chk("rst_acks", {t_ack, s_ack}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr", rom_addr, 0);
            chk("rst_rd_data", rd_data, 0);
            win_q.delete();
            model_next = 0; cur_win = -1; prev_cen = 1; low_cnt = 0;
            have_last = 0; exact_next = 0;
        end else begin
            if (prev_cen && !rom_cen) begin
                int w;
                if (!tr_s && !sr_s) begin
                    flag("grant_without_request");
                    w = 0;
                end else begin
                    if (tr_s && !sr_s)      w = 0;
                    else if (sr_s && !tr_s) w = 1;
                    else                    w = model_next;
                    model_next = 1 - w;
                    win_q.push_back(w);
                    cur_win = w;
                    grant_addr = (w == 1) ? sa_s : ta_s;
                    chk("grant_addr", rom_addr, grant_addr);
                    chk("grant_oen", rom_oen, 0);
                    chk("grant_busy", busy, 1);
                    if (have_last) begin
                        if (exact_next) chk("grant_gap", cyc - last_grant, AC + 2);
                        else            chk("grant_gap_min", (cyc - last_grant) >= (AC + 2), 1);
                    end
                    exact_next = tr_s && sr_s;
                    last_grant = cyc;
                    have_last = 1;
                end
            end
            if (!rom_cen) begin
                low_cnt++;
                if (rom_addr !== grant_addr) chk("addr_hold", rom_addr, grant_addr);
            end
            if (!prev_cen && rom_cen) begin
                chk("cen_low_cycles", low_cnt, AC);
                chk("ack_at_release", t_ack | s_ack, 1);
                low_cnt = 0;
                cur_win = -1;
            end
            if (t_ack && s_ack) flag("double_ack");
            if (t_ack || s_ack) begin
                ack_cnt++;
                if (win_q.size() == 0) begin
                    flag("unexpected_ack");
                end else begin
                    int w;
                    w = win_q.pop_front();
                    chk("ack_side", s_ack ? 1 : 0, w);
                    if (s_ack) begin
                        if (s_exp_q.size() == 0) flag("s_ack_no_expected");
                        else chk("s_rd_data", rd_data, s_exp_q.pop_front());
                    end else begin
                        if (t_exp_q.size() == 0) flag("t_ack_no_expected");
                        else chk("t_rd_data", rd_data, t_exp_q.pop_front());
                    end
                end
            end
            prev_cen = rom_cen;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One read from a requester: raise req, hold until ack, drop in ack cycle.
    task automatic do_read(input int side, input logic [AW-1:0] a, input bit chk_lat);
        bit got;
        int lat;
        got = 0;
        lat = 0;
        if (side == 0) begin
            t_addr = a; t_req = 1'b1; t_exp_q.push_back(rom_word(a));
        end else begin
            s_addr = a; s_req = 1'b1; s_exp_q.push_back(rom_word(a));
        end
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #2;
            if (scribble && !rom_cen && cur_win == side) begin
                if (side == 0) t_addr = AW'($urandom);
                else           s_addr = AW'($urandom);
            end
            if ((side == 0) ? t_ack : s_ack) begin
                got = 1;
                lat = k - 1;
                break;
            end
        end
        if (side == 0) t_req = 1'b0;
        else           s_req = 1'b0;
        if (!got)         flag(side == 0 ? "t_ack_timeout" : "s_ack_timeout");
        else if (chk_lat) chk("ack_latency", lat, AC);
    endtask

    initial begin
        int acks_before;
        bit granted;
        reset = 1'b1; t_req = 1'b0; s_req = 1'b0; t_addr = '0; s_addr = '0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Both raised on the same edge after reset: tile first, then sprite.
        fork
            do_read(0, 18'h02A5E, 0);
            do_read(1, 18'h11111, 0);
        join
        idle(3);

        // Tile-only read with latency check.
        do_read(0, 18'h00123, 1);
        idle(3);

        // Both held continuously for six accesses.
        fork
            begin for (int i = 0; i < 3; i++) do_read(0, AW'($urandom), 0); end
            begin for (int i = 0; i < 3; i++) do_read(1, AW'($urandom), 0); end
        join
        idle(3);

        // Top of the address range.
        do_read(1, 18'h3FFFF, 1);
        idle(2);

        // Requester address changes during the access.
        scribble = 1;
        do_read(0, 18'h0ABCD, 0);
        do_read(1, 18'h2F00D, 0);
        scribble = 0;
        idle(2);

        // Reset three cycles into an access: no ack, prio back to tile.
        acks_before = ack_cnt;
        t_addr = 18'h15555; t_req = 1'b1;
        granted = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (!rom_cen) begin granted = 1; break; end
        end
        if (!granted) flag("reset_case_no_grant");
        idle(2);
        reset = 1'b1; t_req = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(AC + 4);
        chk("no_ack_after_abort", ack_cnt - acks_before, 0);
        // Prior grant was tile, so only a reset prio makes tile win here.
        fork
            do_read(1, 18'h0C0DE, 0);
            do_read(0, 18'h3A5A5, 0);
        join
        idle(3);

        // Random traffic from two independent requesters.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    int g;
                    do_read(0, AW'($urandom), 0);
                    g = $urandom_range(0, 3);
                    if (g > 0) idle(g);
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    int g;
                    do_read(1, AW'($urandom), 0);
                    g = $urandom_range(0, 3);
                    if (g > 0) idle(g);
                end
            end
        join
        idle(5);
        chk("scoreboard_drained", win_q.size() + t_exp_q.size() + s_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gfx_rom_arbiter.md
# gfx_rom_arbiter

Shares one pair of 256K×16 graphics ROMs (low word: 875B11 K13, high word: 875B12 K19) between two fetch requesters: the tile-layer fetch path (requester 0) and the sprite fetch path (requester 1). It drives the common ROM address, chip-enable and output-enable lines, and waits a programmable number of clocks to cover the ROM access time. It then captures the 32-bit word and returns it to the granted requester with a one-cycle acknowledge. The block sits between the fetch engines and the ROM models/pins, and is the only driver of the ROM control lines.

## Interface
- ACCESS_CYCLES, 8: clocks CEn/OEn held low before data capture; ≥1; covers 150 ns ROM access at 48 MHz.
- AW, 18: ROM word-address width.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- t_req  in  1  tile requester read request; level, held until t_ack.
- t_addr  in  AW  tile word address; stable while t_req is high.
- t_ack  out  1  one-cycle pulse; rd_data valid for the tile requester.
- s_req  in  1  sprite requester read request; level, held until s_ack.
- s_addr  in  AW  sprite word address.
- s_ack  out  1  one-cycle pulse; rd_data valid for the sprite requester.
- rd_data  out  32  captured word {hi, lo}; shared, valid only in an ack cycle, held otherwise.
- busy  out  1  high in every state except IDLE.
- rom_addr  out  AW  registered address to both ROMs.
- rom_cen  out  1  active-low chip enable, common to both ROMs.
- rom_oen  out  1  active-low output enable, common to both ROMs.
- rom_lo_data  in  16  K13 data bus; may be Z/X outside an access.
- rom_hi_data  in  16  K19 data bus.

## Operation
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - Samples t_req/s_req.
  - If any request is present, the arbiter grants one. Granted address goes to rom_addr; rom_cen=rom_oen=0; cnt=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - cnt decrements each edge.
  - At the edge where cnt==0: rd_data={rom_hi_data, rom_lo_data}; assert the granted ack; rom_cen=rom_oen=1; go to RECOVER.
- RECOVER: one cycle; ack deasserts; go to IDLE. This bus-turnaround cycle is mandatory.
- Arbitration is two-way round robin:
  - prio register, reset value 0 (tile first).
  - Single request: that request wins regardless of prio.
  - Both requesting: the prio side wins.
  - After any grant, prio points to the non-granted side.
- Requests are sampled only in IDLE. A requester must drop req in its ack cycle; a req still high at the next IDLE sample is a new request.
- Address is latched at grant. Changes to t_addr/s_addr during ACCESS are ignored. rom_addr holds its last value when idle.
- Full 18-bit range is passed through unmodified. 0x3FFFF is legal; there is no wrap logic.
- cnt width is $clog2(ACCESS_CYCLES)+1. ACCESS_CYCLES=1 gives a single ACCESS cycle.

## Timing
- Reset values: state=IDLE, rom_cen=1, rom_oen=1, rom_addr=0, t_ack=s_ack=0, rd_data=0, busy=0, prio=0.
- Grant edge E: ROM lines change after E.
- Capture edge is E+ACCESS_CYCLES. Ack is high in the cycle following that edge.
- Request-sample to ack latency: ACCESS_CYCLES cycles.
- Next grant edge is no earlier than E+ACCESS_CYCLES+2. Peak throughput is one word per ACCESS_CYCLES+2 clocks.
- All outputs are registered; no combinational path from req to ROM lines or ack.
- Reset asserted mid-access: at the next edge all reset values apply. The aborted access produces no ack and prio returns to 0.
- A request arriving during ACCESS or RECOVER waits and is not lost, provided the requester holds it.

## Structure
- Package gfx_rom_pkg:
  - state enum (IDLE, ACCESS, RECOVER);
  - ROM_AW=18, ROM_DW=16, DEFAULT_ACCESS_CYCLES=8.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], prio, advance.
  - Outputs: gnt[1:0] one-hot, next_prio.
  - Purely combinational plus the prio register.
- Top: FSM, counter, address mux and register, data capture.

## Test plan
- Tile-only read, t_addr=0x00123, ACCESS_CYCLES=8, 20 ns clock, ROM model with #70 delay:
  - rom_cen/rom_oen low for exactly 8 cycles;
  - t_ack pulses 8 cycles after sampling;
  - rd_data = {hi[0x123], lo[0x123]};
  - s_ack never asserts.
- t_req and s_req raised on the same edge after reset:
  - tile is served first, then sprite;
  - grant edges are 10 cycles apart;
  - one ack each.
- Both requesters held continuously for 6 accesses: grants alternate T,S,T,S,T,S; no starvation.
- Sprite read at s_addr=0x3FFFF: rom_addr=0x3FFFF; correct data; no wrap.
- Reset pulsed 3 cycles into an access: ROM lines high after the next edge; no ack; the next request is served with prio=0.
- t_addr changed mid-ACCESS: rom_addr is unchanged and rd_data matches the originally latched address.
